mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single unified RAM port between the instruction fetch path (i-side) and the load/store path (d-side) of the CPU.
- Sits between the datapath request signals and the RAM model, which reports progress on ramstate.
- Registered FSM grants one requester at a time and latches that requester's address, write data and direction.
- d-side normally has priority; a starvation counter forces an i-side grant after a bounded run of d-side grants.

Parameters:
STARVE_MAX, 4, consecutive d-side completions allowed while iREN is held before the next grant is forced to the i-side; legal range 1..15

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request
iaddr  in  32  instruction word address (word_t)
iload  out  32  instruction read data (word_t)
iwait  out  1  i-side stall
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address (word_t)
dstore  in  32  data write value (word_t)
dload  out  32  data read data (word_t)
dwait  out  1  d-side stall
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address (word_t)
ramstore  out  32  RAM write data (word_t)
ramload  in  32  RAM read data (word_t)
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
starve_cnt  out  4  current starvation count (debug/visibility)

Behaviour:
- Clock and reset: single clock CLK. nRST is asynchronous and active-low.
- Reset values: state=IDLE; latched addr, store data, write flag and owner all 0; starve_cnt=0; ramREN=ramWEN=0; ramaddr=ramstore=0.
- Reset and waits: iwait and dwait follow their request rules below. While in reset both equal their request inputs.
- Reset mid-access: all state drops immediately. The RAM request is withdrawn in the same cycle and no completion is reported.
- States: IDLE, ISERVE, DSERVE.
- IDLE, grant decision, evaluated every cycle:
  - Forced i-grant: if iREN && starve_cnt==STARVE_MAX, go to ISERVE.
  - Otherwise, if dREN||dWEN, go to DSERVE.
  - Otherwise, if iREN, go to ISERVE.
  - Otherwise stay in IDLE.
- On a grant edge, latch for the granted side:
  - d-side: daddr, dstore, and write flag = dWEN.
  - i-side: iaddr; write flag = 0.
- dREN and dWEN both high: treated as a write.
- ISERVE / DSERVE outputs: ramaddr and ramstore come from the latched values. ramWEN = write flag; ramREN = ~write flag. Outputs are registered-state driven, with no combinational input-to-ram path except the abort rule below.
- Completion: ramstate==ACCESS while serving.
  - Owner's wait=0 in that same cycle.
  - Reads: iload/dload = ramload combinationally in that cycle.
  - Return to IDLE at the next edge.
- ERROR while serving: wait stays high; return to IDLE next edge; the access is re-arbitrated (retry). ERROR does not change starve_cnt.
- FREE/BUSY while serving: hold the state and the latched values.
- Abort: if the owner drops its request while serving, ramREN=ramWEN=0 combinationally in that cycle, then IDLE next edge. No completion and no counter change.
- Wait outputs:
  - iwait = iREN && !(state==ISERVE && ramstate==ACCESS).
  - dwait = (dREN||dWEN) && !(state==DSERVE && ramstate==ACCESS).
- Non-owner read data: iload/dload = 0 when that side is not completing.
- Minimum latency: 2 cycles per access (grant cycle plus ACCESS cycle). Back-to-back accesses each start from IDLE.
- Starvation counter (starve_cnt):
  - +1 on each DSERVE completion while iREN=1, saturating at STARVE_MAX.
  - Cleared on ISERVE completion.
  - Cleared in any cycle with iREN=0.
- Simultaneous iREN and d-request in IDLE with starve_cnt<STARVE_MAX: d-side wins.

Decomposition:
- cpu_types_pkg: add arb_state_t enum {IDLE, ISERVE, DSERVE}. Reuse existing word_t and ramstate_t.
- No sub-module. The starvation counter and FSM are small enough to stay in one module.

Test Plan:
- Reset, then iREN=1 with iaddr=0x40 and RAM returning ACCESS on the 2nd cycle with ramload=0x8C010004 → ramREN=1, ramaddr=0x40 one cycle after the request; iwait=0 and iload=0x8C010004 in the ACCESS cycle; state IDLE next edge.
- iREN and dWEN together (daddr=0x100, dstore=0xDEADBEEF) → DSERVE first with ramWEN=1, ramstore=0xDEADBEEF, iwait=1 throughout; ISERVE starts after the d completion.
- iREN held, d-requests continuous, STARVE_MAX=4 → 4 d completions, starve_cnt reaches 4, 5th grant is ISERVE, starve_cnt returns to 0 after the i completion.
- ERROR injected during DSERVE read (daddr=0x200) → dwait stays 1, IDLE next edge, re-granted; the next ACCESS completes with dload=ramload; starve_cnt unchanged by the ERROR.
- dREN dropped mid-DSERVE with ramstate=BUSY → ramREN=0 in the same cycle, IDLE next edge, a pending iREN is granted the following edge.
- nRST asserted mid-ISERVE → ramREN, ramWEN, ramaddr and starve_cnt go to 0 asynchronously; after release, a fresh grant occurs normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types used by the memory arbiter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISERVE = 2'b01,
    DSERVE = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - i-side/d-side arbiter for the unified RAM port with starvation guard
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                iREN,
  input  word_t               iaddr,
  output word_t               iload,
  output logic                iwait,
  input  logic                dREN,
  input  logic                dWEN,
  input  word_t               daddr,
  input  word_t               dstore,
  output word_t               dload,
  output logic                dwait,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  arb_state_t            state, next_state;
  word_t                 lat_addr, lat_store;
  logic                  lat_wen;
  owner_t                owner;
  logic [STARVE_W-1:0]   starve_q;

  logic d_req, serving, abort, i_done, d_done, force_i;

  assign d_req   = dREN | dWEN;
  assign serving = (state == ISERVE) || (state == DSERVE);
  // The owner withdrawing its request kills the RAM strobe in the same cycle.
  assign abort   = serving && ((owner == OWN_I) ? !iREN : !d_req);
  assign i_done  = (state == ISERVE) && (ramstate == ACCESS) && !abort;
  assign d_done  = (state == DSERVE) && (ramstate == ACCESS) && !abort;
  assign force_i = iREN && (starve_q == STARVE_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (force_i)     next_state = ISERVE;
        else if (d_req)  next_state = DSERVE;
        else if (iREN)   next_state = ISERVE;
        else             next_state = IDLE;
      end
      ISERVE, DSERVE: begin
        if (abort || ramstate == ACCESS || ramstate == ERROR) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    if (serving && !abort) begin
      ramWEN = lat_wen;
      ramREN = !lat_wen;
    end
    ramaddr  = lat_addr;
    ramstore = lat_store;
    iwait    = iREN && !i_done;
    dwait    = d_req && !d_done;
    iload    = i_done ? ramload : '0;
    dload    = (d_done && !lat_wen) ? ramload : '0;
  end

  // Request context is captured only on the grant edge and held while serving.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wen   <= 1'b0;
      owner     <= OWN_I;
    end else if (state == IDLE) begin
      if (next_state == DSERVE) begin
        lat_addr  <= daddr;
        lat_store <= dstore;
        lat_wen   <= dWEN;
        owner     <= OWN_D;
      end else if (next_state == ISERVE) begin
        lat_addr  <= iaddr;
        lat_wen   <= 1'b0;
        owner     <= OWN_I;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else if (!iREN || i_done) begin
      starve_q <= '0;
    end else if (d_done && starve_q != STARVE_LIMIT) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed vectors
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  word_t      iload, dload, ramaddr, ramstore;
  logic       iwait, dwait, ramREN, ramWEN;
  ramstate_t  ramstate;
  logic [3:0] starve_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    word_t addr;
    word_t wdata;
    logic  wen;
    word_t rdata;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .starve_cnt(starve_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic push_i(input word_t a, input word_t r);
    exp_t e;
    e.addr = a; e.wdata = '0; e.wen = 1'b0; e.rdata = r;
    exp_i.push_back(e);
  endtask

  task automatic push_d(input word_t a, input word_t w, input logic wen, input word_t r);
    exp_t e;
    e.addr = a; e.wdata = w; e.wen = wen; e.rdata = r;
    exp_d.push_back(e);
  endtask

  // Monitor: every completion the DUT reports is matched against the scoreboard.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (nRST) begin
      if (iREN && !iwait) begin
        if (exp_i.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_unexpected_done: ramaddr 0x%08h with no expected i access", ramaddr);
        end else begin
          e = exp_i.pop_front();
          chk("i_ramaddr", ramaddr, e.addr);
          chk("i_ramREN", {31'b0, ramREN}, 32'd1);
          chk("iload", iload, e.rdata);
        end
      end
      if ((dREN || dWEN) && !dwait) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected_done: ramaddr 0x%08h with no expected d access", ramaddr);
        end else begin
          e = exp_d.pop_front();
          chk("d_ramaddr", ramaddr, e.addr);
          chk("d_ramWEN", {31'b0, ramWEN}, {31'b0, e.wen});
          chk("d_ramREN", {31'b0, ramREN}, {31'b0, !e.wen});
          if (e.wen) chk("d_ramstore", ramstore, e.wdata);
          else       chk("dload", dload, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    neg();
    chk("rst_ramREN", {31'b0, ramREN}, 0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_starve", {28'b0, starve_cnt}, 0);
    chk("rst_iwait_follows", {31'b0, iwait}, 1);
    chk("rst_dwait_follows", {31'b0, dwait}, 1);
    iREN = 1'b0; dREN = 1'b0;
    #1;
    chk("rst_iwait_low", {31'b0, iwait}, 0);
    tick(); nRST = 1'b1;

    // single i-fetch
    iREN = 1'b1; iaddr = 32'h40;
    neg();
    chk("t1_no_grant_yet", {31'b0, ramREN}, 0);
    chk("t1_iwait", {31'b0, iwait}, 1);
    tick(); ramstate = ACCESS; ramload = 32'h8C010004; push_i(32'h40, 32'h8C010004);
    neg();
    chk("t1_ramaddr", ramaddr, 32'h40);
    tick(); iREN = 1'b0; ramstate = FREE;
    neg();
    chk("t1_idle", {31'b0, ramREN}, 0);

    // simultaneous i and d write: d wins
    tick(); iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick(); ramstate = BUSY;
    neg();
    chk("t2_ramWEN", {31'b0, ramWEN}, 1);
    chk("t2_ramstore", ramstore, 32'hDEADBEEF);
    chk("t2_iwait", {31'b0, iwait}, 1);
    tick(); ramstate = ACCESS; push_d(32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
    neg();
    chk("t2_iwait_dacc", {31'b0, iwait}, 1);
    tick(); dWEN = 1'b0; ramstate = FREE;
    neg();
    chk("t2_starve1", {28'b0, starve_cnt}, 1);
    tick(); ramstate = ACCESS; ramload = 32'h11112222; push_i(32'h44, 32'h11112222);
    neg();
    chk("t2_iserve", {31'b0, ramREN}, 1);
    tick(); iREN = 1'b0; ramstate = FREE;
    neg();
    chk("t2_starve_clr", {28'b0, starve_cnt}, 0);

    // starvation: four d completions, then forced i grant
    tick(); iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      tick(); ramstate = ACCESS; ramload = 32'hD0000000 + k;
      push_d(32'h500 + 4 * k, 32'h0, 1'b0, 32'hD0000000 + k);
      neg();
      chk($sformatf("t3_starve_%0d", k), {28'b0, starve_cnt}, k);
      tick(); ramstate = FREE; daddr = 32'h500 + 4 * (k + 1);
    end
    neg();
    chk("t3_starve_max", {28'b0, starve_cnt}, 4);
    tick(); ramstate = ACCESS; ramload = 32'h12345678; push_i(32'h80, 32'h12345678);
    neg();
    chk("t3_forced_dwait", {31'b0, dwait}, 1);
    tick(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    neg();
    chk("t3_starve_after_i", {28'b0, starve_cnt}, 0);

    // ERROR during d read retries
    tick(); iREN = 1'b1; iaddr = 32'hB0; dREN = 1'b1; daddr = 32'h200;
    tick(); ramstate = ERROR;
    neg();
    chk("t4_dwait_err", {31'b0, dwait}, 1);
    chk("t4_ramREN_err", {31'b0, ramREN}, 1);
    tick(); ramstate = FREE;
    neg();
    chk("t4_idle_after_err", {31'b0, ramREN}, 0);
    chk("t4_starve_err", {28'b0, starve_cnt}, 0);
    tick(); ramstate = ACCESS; ramload = 32'hCAFE0200; push_d(32'h200, 32'h0, 1'b0, 32'hCAFE0200);
    neg();
    tick(); dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    neg();
    chk("t4_starve_retry", {28'b0, starve_cnt}, 1);

    // d abort with pending i
    tick(); dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h90;
    tick(); ramstate = BUSY; dREN = 1'b0;
    neg();
    chk("t5_abort_ramREN", {31'b0, ramREN}, 0);
    chk("t5_abort_ramWEN", {31'b0, ramWEN}, 0);
    chk("t5_abort_iwait", {31'b0, iwait}, 1);
    tick(); ramstate = FREE;
    neg();
    chk("t5_idle", {31'b0, ramREN}, 0);
    chk("t5_starve", {28'b0, starve_cnt}, 0);
    tick(); ramstate = ACCESS; ramload = 32'h00009090; push_i(32'h90, 32'h00009090);
    neg();
    chk("t5_igrant", ramaddr, 32'h90);
    tick(); iREN = 1'b0; ramstate = FREE;

    // async reset mid-ISERVE
    tick(); iREN = 1'b1; iaddr = 32'hA0; dREN = 1'b1; daddr = 32'h400;
    tick(); ramstate = ACCESS; ramload = 32'h44; push_d(32'h400, 32'h0, 1'b0, 32'h44);
    tick(); dREN = 1'b0; ramstate = FREE;
    tick(); ramstate = BUSY;
    #1;
    chk("t6_pre_ramREN", {31'b0, ramREN}, 1);
    chk("t6_pre_starve", {28'b0, starve_cnt}, 1);
    #1; nRST = 1'b0;
    #1;
    chk("t6_rst_ramREN", {31'b0, ramREN}, 0);
    chk("t6_rst_ramWEN", {31'b0, ramWEN}, 0);
    chk("t6_rst_ramaddr", ramaddr, 0);
    chk("t6_rst_starve", {28'b0, starve_cnt}, 0);
    chk("t6_rst_iwait", {31'b0, iwait}, 1);
    tick(); nRST = 1'b1; ramstate = FREE;
    tick(); ramstate = ACCESS; ramload = 32'h0000A0A0; push_i(32'hA0, 32'h0000A0A0);
    neg();
    chk("t6_regrant", ramaddr, 32'hA0);
    tick(); iREN = 1'b0; ramstate = FREE;
    tick();

    chk("sb_i_empty", exp_i.size(), 0);
    chk("sb_d_empty", exp_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
